// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block and its divider.
`timescale 1ns/1ps
package pwm_capture_pkg;
   localparam int DUTY_W = 8;
   localparam logic [DUTY_W-1:0] DUTY_FULL = '1;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } state_e;
endpackage

// File: rtl/pwm_capture_if.sv
// PWM capture bus: the raw input pin plus the measurement results.
// Handshake: duty_valid is a single-cycle strobe; duty/high_cycles/period_cycles/stuck are
// valid in that cycle and hold until the next strobe. There is no ready; a consumer must sample on the strobe.
`timescale 1ns/1ps
interface pwm_capture_if import pwm_capture_pkg::*; #(
   parameter int CNT_W = 25
);
   logic              pwm_in;
   logic [DUTY_W-1:0] duty;
   logic [CNT_W-1:0]  high_cycles;
   logic [CNT_W-1:0]  period_cycles;
   logic              duty_valid;
   logic              stuck;
   logic              overrun;
   state_e            dbg_state;

   modport master (
      input  pwm_in,
      output duty, high_cycles, period_cycles, duty_valid, stuck, overrun, dbg_state
   );
   modport slave (
      output pwm_in,
      input  duty, high_cycles, period_cycles, duty_valid, stuck, overrun, dbg_state
   );
endinterface

// File: rtl/pwm_capture_div.sv
// Restoring divider: DUTY_W quotient bits of dividend*2^DUTY_W/divisor, one bit per clock, MSB first.
// Requires dividend < divisor, so the quotient never saturates.
`timescale 1ns/1ps
module pwm_capture_div import pwm_capture_pkg::*; #(
   parameter int CNT_W = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  dividend,
   input  logic [CNT_W-1:0]  divisor,
   output logic              busy,
   output logic              done,
   output logic [DUTY_W-1:0] quot
);
   localparam logic [2:0] LAST_STEP = 3'(DUTY_W - 1);

   logic [CNT_W-1:0]  rem_q;
   logic [CNT_W-1:0]  dsr_q;
   logic [DUTY_W-2:0] q_q;
   logic [2:0]        step_q;
   logic              busy_q;
   logic [CNT_W-1:0]  rem_sh;
   logic              take;

   // rem < divisor, so the true difference always fits in CNT_W bits even when rem<<1 carries out
   always_comb begin
      rem_sh = {rem_q[CNT_W-2:0], 1'b0};
      take   = rem_q[CNT_W-1] | (rem_sh >= dsr_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         dsr_q  <= '0;
         q_q    <= '0;
         step_q <= '0;
         busy_q <= 1'b0;
      end else if (busy_q) begin
         rem_q  <= take ? (rem_sh - dsr_q) : rem_sh;
         q_q    <= quot[DUTY_W-2:0];
         step_q <= step_q + 3'd1;
         if (step_q == LAST_STEP) busy_q <= 1'b0;
      end else if (start) begin
         rem_q  <= dividend;
         dsr_q  <= divisor;
         q_q    <= '0;
         step_q <= '0;
         busy_q <= 1'b1;
      end
   end

   assign busy = busy_q;
   assign done = busy_q && (step_q == LAST_STEP);
   assign quot = {q_q, take};
endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and reports duty on a 0..255 scale.
// A static input is reported as 0 or full scale after TIMEOUT cycles without edges.
`timescale 1ns/1ps
module pwm_capture import pwm_capture_pkg::*; #(
   parameter int CNT_W   = 25,
   parameter int TIMEOUT = 27000000
) (
   input logic           clk,
   input logic           rst,
   pwm_capture_if.master bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT - 1);

   logic sync1_q, sync2_q, sync2_d_q, rise_q, fall_q;
   logic [CNT_W-1:0] idle_q, cnt_q, high_meas_q, res_high_q, res_period_q;
   logic [CNT_W-1:0] high_out_q, period_out_q;
   logic [DUTY_W-1:0] duty_q, div_quot;
   logic duty_valid_q, stuck_q, overrun_q;
   logic div_busy, div_done, div_start;
   logic evt, tmo_hit, cnt_restart, latch_high, ovr_hit;
   state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         sync2_d_q <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else begin
         sync1_q   <= bus.pwm_in;
         sync2_q   <= sync1_q;
         sync2_d_q <= sync2_q;
         rise_q    <= sync2_q & ~sync2_d_q;
         fall_q    <= ~sync2_q & sync2_d_q;
      end
   end

   // An edge in the same cycle always beats a timeout
   assign evt     = rise_q | fall_q;
   assign tmo_hit = (idle_q >= TMO_LIM) && !div_busy && !evt;

   always_ff @(posedge clk) begin
      if (rst || evt || tmo_hit) idle_q <= '0;
      else if (idle_q != CNT_MAX) idle_q <= idle_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= WAIT_RISE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cnt_restart = 1'b0;
      latch_high  = 1'b0;
      div_start   = 1'b0;
      ovr_hit     = 1'b0;
      if (tmo_hit) begin
         state_d = WAIT_RISE;
      end else begin
         case (state_q)
            WAIT_RISE: if (rise_q) begin
               cnt_restart = 1'b1;
               state_d     = MEAS_HIGH;
            end
            MEAS_HIGH: if (fall_q) begin
               latch_high = 1'b1;
               state_d    = MEAS_LOW;
            end
            MEAS_LOW: if (rise_q) begin
               cnt_restart = 1'b1;
               state_d     = MEAS_HIGH;
               ovr_hit     = div_busy;
               div_start   = !div_busy;
            end
            default: state_d = WAIT_RISE;
         endcase
      end
   end

   // The event cycle itself counts as the first cycle of the new period
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         high_meas_q  <= '0;
         res_high_q   <= '0;
         res_period_q <= '0;
      end else begin
         if (cnt_restart)          cnt_q <= CNT_W'(1);
         else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
         if (latch_high) high_meas_q <= cnt_q;
         if (div_start) begin
            res_high_q   <= high_meas_q;
            res_period_q <= cnt_q;
         end
      end
   end

   pwm_capture_div #(.CNT_W(CNT_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (high_meas_q),
      .divisor  (cnt_q),
      .busy     (div_busy),
      .done     (div_done),
      .quot     (div_quot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_q       <= '0;
         high_out_q   <= '0;
         period_out_q <= '0;
         duty_valid_q <= 1'b0;
         stuck_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         duty_valid_q <= 1'b0;
         overrun_q    <= ovr_hit;
         if (div_done) begin
            duty_q       <= div_quot;
            high_out_q   <= res_high_q;
            period_out_q <= res_period_q;
            duty_valid_q <= 1'b1;
            stuck_q      <= 1'b0;
         end else if (tmo_hit) begin
            duty_q       <= sync2_q ? DUTY_FULL : '0;
            high_out_q   <= '0;
            period_out_q <= '0;
            duty_valid_q <= 1'b1;
            stuck_q      <= 1'b1;
         end
      end
   end

   assign bus.duty          = duty_q;
   assign bus.high_cycles   = high_out_q;
   assign bus.period_cycles = period_out_q;
   assign bus.duty_valid    = duty_valid_q;
   assign bus.stuck         = stuck_q;
   assign bus.overrun       = overrun_q;
   assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: a timestamp-based reference model checked every cycle,
// plus literal expectations on the reported values and their timing.
`timescale 1ns/1ps
module tb_pwm_capture;
   import pwm_capture_pkg::*;

   localparam int CNT_W = 25;
   localparam int TMO   = 1000;
   localparam int MAXC  = 16384;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   pwm_capture_if #(.CNT_W(CNT_W)) bus();

   pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- recorded input history ----------------
   bit lvl  [MAXC];
   bit rstv [MAXC];

   // ---------------- reference model ----------------
   // Input changing in cycle n gives an event in cycle n+3; a result started by event E is
   // visible in cycle E+9; an input static for TMO cycles is reported as stuck.
   int m_phase = 0;        // 0 wait for rise, 1 high, 2 low
   int m_rise_t = 0;
   int m_high = 0;
   int m_busy_until = -100;
   int m_pend_t = -1;
   int m_pend_duty = 0, m_pend_high = 0, m_pend_per = 0;
   int m_last_clear = 0;
   int e_duty = 0, e_high = 0, e_per = 0;
   bit e_stuck = 0, e_valid = 0, e_ovr = 0;

   function automatic bit ev_ok(input int e);
      if (e < 5) return 1'b0;
      return !(rstv[e-1] || rstv[e-2] || rstv[e-3] || rstv[e-4]);
   endfunction

   task automatic model_step(input int t);
      int e;
      bit rise, fall, busy;
      e = t - 1;
      e_valid = 1'b0;
      e_ovr   = 1'b0;
      if (rstv[e]) begin
         m_phase = 0; m_busy_until = -100; m_pend_t = -1; m_last_clear = t;
         e_duty = 0; e_high = 0; e_per = 0; e_stuck = 1'b0;
         return;
      end
      rise = ev_ok(e) && lvl[e-3] && !lvl[e-4];
      fall = ev_ok(e) && !lvl[e-3] && lvl[e-4];
      busy = (e <= m_busy_until);
      if (m_pend_t == t) begin
         e_duty = m_pend_duty; e_high = m_pend_high; e_per = m_pend_per;
         e_stuck = 1'b0; e_valid = 1'b1; m_pend_t = -1;
      end
      if (rise || fall) begin
         m_last_clear = t;
      end else if (!busy && t >= m_last_clear + TMO) begin
         e_duty = lvl[e-2] ? 255 : 0; e_high = 0; e_per = 0;
         e_stuck = 1'b1; e_valid = 1'b1; m_phase = 0; m_last_clear = t;
      end
      if (rise) begin
         if (m_phase == 2) begin
            if (busy) begin
               e_ovr = 1'b1;
            end else begin
               m_pend_t    = e + 9;
               m_pend_high = m_high;
               m_pend_per  = e - m_rise_t;
               m_pend_duty = (m_high * 256) / (e - m_rise_t);
               m_busy_until = e + 8;
            end
         end
         m_rise_t = e;
         m_phase  = 1;
      end
      if (fall && m_phase == 1) begin
         m_high  = e - m_rise_t;
         m_phase = 2;
      end
   endtask

   // ---------------- scoreboard / observation log ----------------
   int obs_duty[$], obs_high[$], obs_per[$], obs_stuck[$], obs_cyc[$];
   int ovr_seen = 0;
   int rise_q[$];

   task automatic clear_obs();
      obs_duty.delete(); obs_high.delete(); obs_per.delete();
      obs_stuck.delete(); obs_cyc.delete(); rise_q.delete();
      ovr_seen = 0;
   endtask

   function automatic int qget(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Compare process: every cycle after the first edge, all outputs against the model
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < MAXC) begin
         lvl[cyc]  = bus.pwm_in;
         rstv[cyc] = rst;
         model_step(cyc);
         n_checks++;
         if (bus.duty !== 8'(e_duty) || bus.high_cycles !== CNT_W'(e_high) ||
             bus.period_cycles !== CNT_W'(e_per) || bus.stuck !== e_stuck ||
             bus.duty_valid !== e_valid || bus.overrun !== e_ovr) begin
            n_err++;
            $display("FAIL cycle_%0d outputs: got duty=%0d high=%0d period=%0d stuck=%0b valid=%0b ovr=%0b, expected duty=%0d high=%0d period=%0d stuck=%0b valid=%0b ovr=%0b",
                     cyc, bus.duty, bus.high_cycles, bus.period_cycles, bus.stuck, bus.duty_valid,
                     bus.overrun, e_duty, e_high, e_per, e_stuck, e_valid, e_ovr);
         end
         if (bus.duty_valid === 1'b1) begin
            obs_duty.push_back(int'(bus.duty));
            obs_high.push_back(int'(bus.high_cycles));
            obs_per.push_back(int'(bus.period_cycles));
            obs_stuck.push_back(int'(bus.stuck));
            obs_cyc.push_back(cyc);
         end
         if (bus.overrun === 1'b1) ovr_seen++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input bit v, input bit r);
      @(posedge clk);
      #1;
      bus.pwm_in = v;
      rst = r;
   endtask

   task automatic periods(input int h, input int p, input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < p; i++) begin
            tick(i < h, 1'b0);
            if (i == 0) rise_q.push_back(cyc);
         end
      end
   endtask

   // ---------------- directed stimulus ----------------
   int rel_c, n1, nr;
   int exp4_duty[5]  = '{0, 0, 255, 76, 76};
   int exp4_stuck[5] = '{1, 1, 1, 0, 0};
   int exp7_duty[10] = '{76, 10, 10, 10, 20, 20, 20, 30, 30, 30};

   initial begin
      bus.pwm_in = 1'b0;
      rstv[0] = 1'b1;
      repeat (5) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("reset_duty", int'(bus.duty), 0);
      chk("reset_high", int'(bus.high_cycles), 0);
      chk("reset_period", int'(bus.period_cycles), 0);
      chk("reset_stuck", int'(bus.stuck), 0);

      // 64/256: first partial period discarded, then one result per rise
      clear_obs();
      periods(64, 256, 4);
      chk("t1_count", obs_duty.size(), 3);
      chk("t1_duty", qget(obs_duty, 0), 64);
      chk("t1_high", qget(obs_high, 0), 64);
      chk("t1_period", qget(obs_per, 0), 256);
      chk("t1_latency", qget(obs_cyc, 0) - rise_q[1], 12);
      chk("t1_repeat", qget(obs_cyc, 2) - qget(obs_cyc, 1), 256);

      // 30/100 -> floor(7680/100) = 76
      clear_obs();
      periods(30, 100, 3);
      chk("t2_count", obs_duty.size(), 3);
      chk("t2_duty", qget(obs_duty, 2), 76);
      chk("t2_high", qget(obs_high, 2), 30);
      chk("t2_period", qget(obs_per, 2), 100);
      chk("t2_stuck", qget(obs_stuck, 2), 0);

      // Stuck low after reset, stuck high, then recovery
      clear_obs();
      repeat (5) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      rel_c = cyc;
      repeat (2009) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      n1 = cyc;
      repeat (1099) tick(1'b1, 1'b0);
      periods(30, 100, 4);
      chk("t4_count", obs_duty.size(), 5);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_duty_%0d", i), qget(obs_duty, i), exp4_duty[i]);
         chk($sformatf("t4_stuck_%0d", i), qget(obs_stuck, i), exp4_stuck[i]);
      end
      chk("t4_first_tmo_cycle", qget(obs_cyc, 0) - rel_c, 1000);
      chk("t4_tmo_repeat", qget(obs_cyc, 1) - qget(obs_cyc, 0), 1000);
      chk("t4_high_tmo_cycle", qget(obs_cyc, 2) - n1, 1004);
      chk("t4_stuck_period", qget(obs_per, 0), 0);

      // Period 6: divider still busy on every other rise
      clear_obs();
      repeat (10) tick(1'b0, 1'b0);
      periods(3, 6, 10);
      repeat (20) tick(1'b0, 1'b0);
      chk("t5_overruns", ovr_seen, 5);
      chk("t5_count", obs_duty.size(), 5);
      chk("t5_first_duty", qget(obs_duty, 0), 69);
      chk("t5_last_duty", qget(obs_duty, 4), 128);
      chk("t5_last_high", qget(obs_high, 4), 3);
      chk("t5_last_period", qget(obs_per, 4), 6);

      // Reset in the middle of a division
      periods(30, 100, 2);
      tick(1'b1, 1'b0);
      nr = cyc;
      clear_obs();
      repeat (6) tick(1'b1, 1'b0);
      repeat (6) tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("t6_rst_duty", int'(bus.duty), 0);
      chk("t6_rst_period", int'(bus.period_cycles), 0);
      repeat (8) tick(1'b0, 1'b0);
      chk("t6_no_valid", obs_duty.size(), 0);
      chk("t6_window", cyc - nr, 21);
      periods(30, 100, 3);
      chk("t6_count", obs_duty.size(), 2);
      chk("t6_first_cycle", qget(obs_cyc, 0) - rise_q[1], 12);
      chk("t6_first_duty", qget(obs_duty, 0), 76);

      // Compare stepping 10 -> 20 -> 30 on a 256-cycle period
      clear_obs();
      periods(10, 256, 3);
      periods(20, 256, 3);
      periods(30, 256, 4);
      chk("t7_count", obs_duty.size(), 10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("t7_duty_%0d", i), qget(obs_duty, i), exp7_duty[i]);

      repeat (20) tick(1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform and reports its duty cycle as an 8-bit compare-equivalent value, 0..255, on the same scale as the pwm generator's compare input.
It also reports the raw high-time and period in clk cycles.
It closes the loop on the LED/PWM demo by letting the design read back a PWM signal from a pin or from a loopback of pwm.
A static (edge-less) input is detected by timeout and reported as 0% or full-scale.

Parameters:
CNT_W, 25, width of high/period/timeout counters; must hold TIMEOUT (25 bits covers 1 s at 27 MHz)
TIMEOUT, 27000000, clk cycles without any input edge before the input is declared stuck
DUTY_W, 8, duty output width; fixed to match the pwm compare width

Ports:
clk  input  1  system clock; only clock
rst  input  1  synchronous, active-high reset
pwm_in  input  1  asynchronous PWM input
duty  output  DUTY_W  floor(high_cycles*256/period_cycles); 0 or 255 when stuck
high_cycles  output  CNT_W  synchronized-high cycles in the last measured period
period_cycles  output  CNT_W  cycles between the last two rising events
duty_valid  output  1  one-cycle pulse when the outputs update
stuck  output  1  level; 1 while the last update was a timeout
overrun  output  1  one-cycle pulse when a measurement is dropped

Behaviour:
- Reset: all outputs 0; sync flops 0; FSM to WAIT_RISE; counters 0; divider idle.
- Input path: 2-FF synchronizer, then a registered edge detector.
  - A rise/fall "event" is asserted in cycle E, 3 clk cycles after the pwm_in transition.
- FSM states:
  - WAIT_RISE: on a rise event, clear the cycle counter and go to MEAS_HIGH. No output is produced; the first partial period after reset is discarded.
  - MEAS_HIGH: on a fall event, latch the high count and go to MEAS_LOW.
  - MEAS_LOW: on a rise event, latch the period and start the divider (if idle), restart the cycle counter, and go to MEAS_HIGH.
- Counting semantics: high_cycles = number of cycles the synchronized input was 1; period_cycles = cycles from one rise event to the next. An ideal input with high H and period P yields exactly H and P.
- Divider:
  - 8-step restoring division; remainder init = high, step: r<<=1; if r>=period then r-=period and qbit=1; MSB first.
  - high<period always, so the quotient is <256 and needs no saturation.
  - Start in cycle E+1, last step in cycle E+8; duty/high_cycles/period_cycles update and duty_valid=1 in cycle E+9; stuck cleared on that same cycle.
- Overrun: a rise event in MEAS_LOW while the divider is busy (period < 9 cycles) drops that measurement and pulses overrun. Outputs are unchanged, and counting restarts normally.
- Timeout:
  - An idle counter resets on every rise/fall event, otherwise increments, saturating.
  - On reaching TIMEOUT in any state other than divider-busy: duty = 0 if the synchronized level is 0, else 255; high_cycles = period_cycles = 0; stuck = 1; duty_valid pulse; FSM to WAIT_RISE; idle counter cleared.
  - Further timeouts repeat every TIMEOUT cycles while the input stays static.
- Counter overflow: the cycle counter saturates at all-ones. The timeout fires before a saturated period can be reported (TIMEOUT < 2^CNT_W).
- Simultaneous events: timeout and edge in the same cycle → the edge wins, and the idle counter clears.
- rst mid-measurement or mid-division: the in-flight result is discarded; no duty_valid follows.

Decomposition:
- Shared header pwm_defs.vh: DUTY_W=8, FSM state encodings (WAIT_RISE, MEAS_HIGH, MEAS_LOW), DUTY_FULL=255.
- One sub-module, pwm_div: 8-cycle restoring divider with start/busy/done and a quotient output. It has the same clk/rst and is reusable by future capture blocks.

Test Plan:
- Loopback pwm, compare=64, 256-cycle period → after the 2nd rise: high_cycles=64, period_cycles=256, duty=64, duty_valid pulse exactly 9 cycles after the rise event; repeats each period.
- Direct stimulus high=30, period=100 → duty=76 (floor 7680/100), high=30, period=100, stuck=0.
- TIMEOUT=1000; hold pwm_in=0 after reset → first duty_valid at ~1000 cycles, duty=0, stuck=1; hold 1 instead → duty=255, stuck=1; apply a valid PWM afterwards → stuck clears on the first real measurement.
- Period 6 (high 3) → overrun pulses on alternate rises; only periods finishing with the divider idle report duty=128.
- Assert rst during the divider's 4th step → no duty_valid, all outputs 0. After release, the first duty_valid comes only after one full discarded partial period plus one measured period.
- Step the compare value 10→20→30 on a 256-cycle pwm loopback → duty reports 10, 20, 30 in order, with no glitch values between them.
